// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue stage in front of a combinational ALU. Takes one operation over a
//   valid/ready handshake, registers operands and opcode onto the ALU inputs,
//   waits SETTLE_CYCLES edges, then captures the ALU result and flags into an
//   output register that is held until the consumer accepts it.
//
// Parameters
//   SETTLE_CYCLES  edges from operand launch to result capture (1..15)
//   WIDTH          operand/result width, must match the ALU
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_a, in_b, in_opcode         operation to issue
//   alu_a, alu_b, alu_opcode      registered operands/opcode driving the ALU
//   alu_c, alu_d                  ALU result and flags
//   out_valid/out_ready           downstream handshake
//   out_c, out_d, out_opcode      captured result, flags and opcode
//   busy                          high whenever the sequencer is not idle
//   op_count                      completed transfers, wraps at 16 bits
//                                 (present only with ALU_OP_SEQ_STATS_EN)
//
// Optional feature macro: ALU_OP_SEQ_STATS_EN
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [2:0]       alu_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [2:0]       out_d,
  output logic [2:0]       out_opcode,
  output logic             busy
`ifdef ALU_OP_SEQ_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       launch;
  logic       capture;
  logic       xfer;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    launch     = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          launch     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          xfer       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Launch stage: operands onto the ALU. Capture stage: result into out_*.
  // Reset clears the data registers as well so an aborted result never leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'd0;
      out_c      <= '0;
      out_d      <= 3'd0;
      out_opcode <= 3'd0;
      out_valid  <= 1'b0;
    end else begin
      if (launch) begin
        alu_a      <= in_a;
        alu_b      <= in_b;
        alu_opcode <= in_opcode;
      end
      if (capture) begin
        out_c      <= alu_c;
        out_d      <= alu_d;
        out_opcode <= alu_opcode;
        out_valid  <= 1'b1;
      end else if (xfer) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_OP_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (xfer) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
  localparam int S = 2;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    in_opcode;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_opcode;
  logic [W-1:0]  alu_c;
  logic [2:0]    alu_d;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_c;
  logic [2:0]    out_d;
  logic [2:0]    out_opcode;
  logic          busy;
`ifdef ALU_OP_SEQ_STATS_EN
  logic [15:0]   op_count;
  int            exp_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_d(alu_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_d(out_d), .out_opcode(out_opcode),
    .busy(busy)
`ifdef ALU_OP_SEQ_STATS_EN
    , .op_count(op_count)
`endif
  );

  // Behavioural ALU: result plus flags {zero, negative, carry-out of add}.
  function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W:0]   wide;
    logic [W-1:0] c;
    wide = '0;
    case (op)
      3'd0: c = a << b[4:0];
      3'd1: c = W'($signed(a) >>> b[4:0]);
      3'd2: begin wide = {1'b0, a} + {1'b0, b}; c = wide[W-1:0]; end
      3'd3: c = a - b;
      3'd4: c = W'(a * b);
      3'd5: c = a & b;
      3'd6: c = a | b;
      default: c = ~a;
    endcase
    return {c == '0, c[W-1], (op == 3'd2) ? wide[W] : 1'b0, c};
  endfunction

  always_comb begin
    {alu_d, alu_c} = alu_fn(alu_a, alu_b, alu_opcode);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, hold out_ready low for 'stall' cycles in DONE
  // while offering a decoy operation, then complete the transfer.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int stall);
    logic [W+2:0] exp;
    exp = alu_fn(a, b, op);
    check("idle_in_ready", W'(in_ready), 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_opcode = op;
    step();
    in_valid = 1'b0;
    check("launch_alu_a", alu_a, a);
    check("launch_alu_b", alu_b, b);
    check("launch_opcode", W'(alu_opcode), W'(op));
    check("launch_busy", W'(busy), 1);
    for (int k = 1; k < S; k++) begin
      step();
      check("settle_no_valid", W'(out_valid), 0);
    end
    step();
    check("cap_valid", W'(out_valid), 1);
    check("cap_c", out_c, exp[W-1:0]);
    check("cap_d", W'(out_d), W'(exp[W+2:W]));
    check("cap_opcode", W'(out_opcode), W'(op));
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1; in_a = ~a; in_b = ~b; in_opcode = ~op;
      step();
      check("bp_valid", W'(out_valid), 1);
      check("bp_c", out_c, exp[W-1:0]);
      check("bp_in_ready", W'(in_ready), 0);
      check("bp_alu_a", alu_a, a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("xfer_valid_low", W'(out_valid), 0);
    check("xfer_idle", W'(in_ready), 1);
`ifdef ALU_OP_SEQ_STATS_EN
    exp_count = (exp_count + 1) & 16'hFFFF;
    check("op_count", W'(op_count), W'(exp_count));
`endif
  endtask

  initial begin
    logic [W+2:0] e1, e2;
`ifdef ALU_OP_SEQ_STATS_EN
    exp_count = 0;
`endif
    rst = 1'b1; in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 32'h12345678;
    in_opcode = 3'd2; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_busy", W'(busy), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_d", W'(out_d), 0);
    check("rst_out_opcode", W'(out_opcode), 0);
`ifdef ALU_OP_SEQ_STATS_EN
    check("rst_op_count", W'(op_count), 0);
`endif

    // Single multiply, then backpressured add.
    run_op(32'd2, 32'd3, 3'd4, 0);
    check("mul_result_6", out_c, 32'd6);
    run_op(32'd5, 32'd7, 3'd2, 10);
    check("add_result_12", out_c, 32'd12);

    // Back-to-back with out_ready tied high: interval must be S+2 edges.
    e1 = alu_fn(32'h00010000, 32'h00010000, 3'd4);
    e2 = alu_fn(32'hFFFFFFFE, 32'd3, 3'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h00010000; in_b = 32'h00010000; in_opcode = 3'd4;
    step();
    in_a = 32'hFFFFFFFE; in_b = 32'd3; in_opcode = 3'd3;
    for (int k = 1; k < S; k++) begin
      step();
      check("b2b_settle1", W'(out_valid), 0);
    end
    step();
    check("b2b_valid1", W'(out_valid), 1);
    check("b2b_c1", out_c, e1[W-1:0]);
    check("b2b_d1", W'(out_d), W'(e1[W+2:W]));
    step();
    check("b2b_gap_valid", W'(out_valid), 0);
    check("b2b_gap_ready", W'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("b2b_accept2", alu_a, 32'hFFFFFFFE);
    check("b2b_busy2", W'(busy), 1);
    for (int k = 1; k < S; k++) step();
    step();
    check("b2b_valid2", W'(out_valid), 1);
    check("b2b_c2", out_c, e2[W-1:0]);
    check("b2b_d2", W'(out_d), W'(e2[W+2:W]));
    check("b2b_op2", W'(out_opcode), 3);
    step();
    out_ready = 1'b0;
    check("b2b_done", W'(in_ready), 1);
`ifdef ALU_OP_SEQ_STATS_EN
    exp_count = exp_count + 2;
    check("b2b_op_count", W'(op_count), W'(exp_count));
`endif

    // Reset one edge after acceptance: result must never appear.
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; in_opcode = 3'd6;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", W'(in_ready), 1);
    check("abort_alu_a", alu_a, 0);
    for (int k = 0; k < S + 2; k++) begin
      step();
      check("abort_no_valid", W'(out_valid), 0);
    end
`ifdef ALU_OP_SEQ_STATS_EN
    exp_count = 0;
    check("abort_op_count", W'(op_count), 0);
`endif
    run_op(32'hFFFFFFF0, 32'd4, 3'd1, 1);

    // Randomised operations against the behavioural model.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = W'($urandom_range(0, 31));
      run_op(ra, rb, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage for the combinational 32-bit ALU (3-bit opcode, 32-bit result c, 3-bit flag output d). Accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. Waits a fixed settle interval, then captures the ALU result and flags into an output register that is held until the consumer takes it. This gives the ALU a clean registered boundary so it can be placed in a clocked datapath.

Parameters:
SETTLE_CYCLES, 2, clock edges from operand launch to result capture; legal range 1..15
WIDTH, 32, operand/result width; must match the ALU

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream operation valid
in_ready  output  1  sequencer can accept an operation
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_opcode  input  3  000 sla, 001 sra, 010 add, 011 sub, 100 mul, 101 and, 110 or, 111 not
alu_a  output  WIDTH  registered operand to ALU a
alu_b  output  WIDTH  registered operand to ALU b
alu_opcode  output  3  registered opcode to ALU
alu_c  input  WIDTH  ALU result
alu_d  input  3  ALU flags
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_c  output  WIDTH  captured result
out_d  output  3  captured flags
out_opcode  output  3  opcode that produced out_c/out_d
busy  output  1  high when state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at an edge, all registers clear: state=IDLE, counter=0, alu_a/alu_b/alu_opcode=0, out_c/out_d/out_opcode=0, out_valid=0.
- Combinational outputs: in_ready=(state==IDLE), busy=(state!=IDLE).
- Reset mid-operation aborts the operation. A pending result is discarded and is never presented.
- FSM states: IDLE, SETTLE, DONE.
- IDLE: on an edge with in_valid=1, latch in_a, in_b and in_opcode into the alu_* registers, load counter=SETTLE_CYCLES-1, and go to SETTLE. With in_valid=0, hold.
- SETTLE: alu_* registers are held stable.
  - counter!=0: decrement the counter.
  - counter==0: capture alu_c into out_c and alu_d into out_d, copy alu_opcode into out_opcode, set out_valid=1, and go to DONE.
- DONE: out_* and alu_* are held. On an edge with out_ready=1, clear out_valid and go to IDLE. With out_ready=0, hold indefinitely.
- Latency: an operation accepted at edge N produces out_valid high after edge N+SETTLE_CYCLES. The minimum issue interval is SETTLE_CYCLES+2 edges.
- out_ready is ignored outside DONE. in_valid and the in_* inputs are ignored outside IDLE; no second operation is queued.
- If out_ready is already high when out_valid rises, the transfer completes on the following edge.
- in_valid is treated as a level. The upstream must hold in_* stable while in_valid=1 and in_ready=0.
- The sequencer performs no arithmetic. alu_c and alu_d pass through bit-exact.

Optional Feature:
ALU_OP_SEQ_STATS_EN
- Defined: adds output op_count[15:0]. Reset to 0. Increments by 1 on every completed out_valid&&out_ready transfer and wraps 0xFFFF->0x0000. Not incremented by operations aborted by reset.
- Undefined: the op_count port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: rst high for 2 edges while in_valid=1 -> in_ready=1, busy=0, out_valid=0, alu_a=alu_b=0, out_c=0 after release.
- Single mul, SETTLE_CYCLES=2, behavioural ALU model in bench: a=2, b=3, opcode=100 accepted at edge N -> alu_a=2, alu_b=3 after N; out_valid=1 after N+2 with out_c=6, out_opcode=100; out_ready=1 -> IDLE on the next edge.
- Backpressure: add a=5, b=7, out_ready=0 for 10 cycles -> out_valid stays 1, out_c=12 stable, in_ready=0 and a second in_valid is ignored; raising out_ready completes exactly one transfer.
- Back-to-back: two queued operations, mul a=0x00010000, b=0x00010000 then sub a=0xFFFFFFFE, b=3, out_ready tied high -> results appear in order, issue interval is SETTLE_CYCLES+2 edges, and out_c/out_d match the model.
- Reset mid-SETTLE: assert rst one edge after acceptance -> out_valid never rises, state returns to IDLE, and the next operation completes normally.
- Stats, with ALU_OP_SEQ_STATS_EN defined: preload by running 65536 transfers -> op_count wraps to 0; an aborted operation leaves op_count unchanged.
